// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: pipeline control inputs and the fetch address / status outputs.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misaligned;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, redirect_valid, redirect_target, trap, call, ret,
    input  pc, pc_valid, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap, call, ret,
    output pc, pc_valid, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential advance, stall, redirect, trap.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              RAS_DEPTH    = 4
) (
  input logic     clock,
  input logic     reset,
  pc_gen_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic            pc_valid_r, pc_valid_nxt_s;
  logic            misaligned_r, misaligned_nxt_s;
  logic            pend_valid_r, pend_valid_nxt_s;
  logic [XLEN-1:0] pend_target_r, pend_target_nxt_s;

  logic [XLEN-1:0] seq_pc_s;
  logic            redir_any_s;
  logic [XLEN-1:0] redir_tgt_s;
  logic            redir_bad_s;
  logic            ras_push_s, ras_pop_s, ras_clr_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_nonempty_s;

  // A live redirect is newer than anything buffered during a stall, so it wins.
  assign seq_pc_s    = pc_r + XLEN'(4);
  assign redir_any_s = bus.redirect_valid | pend_valid_r;
  assign redir_tgt_s = bus.redirect_valid ? bus.redirect_target : pend_target_r;
  assign redir_bad_s = (redir_tgt_s[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= BOOT;
    else       state_r <= state_nxt_s;
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN, STALLED: begin
        if (bus.trap)                      state_nxt_s = RUN;
        else if (bus.stall)                state_nxt_s = STALLED;
        else if (redir_any_s && redir_bad_s) state_nxt_s = HALT;
        else                               state_nxt_s = RUN;
      end
      HALT: begin
        if (bus.trap) state_nxt_s = RUN;
        else          state_nxt_s = HALT;
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // Next values of pc, status outputs, pending redirect and RAS operations.
  always_comb begin
    pc_nxt_s          = pc_r;
    pc_valid_nxt_s    = pc_valid_r;
    misaligned_nxt_s  = 1'b0;
    pend_valid_nxt_s  = pend_valid_r;
    pend_target_nxt_s = pend_target_r;
    ras_push_s        = 1'b0;
    ras_pop_s         = 1'b0;
    ras_clr_s         = 1'b0;
    case (state_r)
      BOOT: pc_valid_nxt_s = 1'b1;
      RUN, STALLED: begin
        if (bus.trap) begin
          pc_nxt_s         = TRAP_VECTOR;
          pc_valid_nxt_s   = 1'b1;
          pend_valid_nxt_s = 1'b0;
          ras_clr_s        = 1'b1;
        end else if (bus.stall) begin
          if (bus.redirect_valid) begin
            pend_valid_nxt_s  = 1'b1;
            pend_target_nxt_s = bus.redirect_target;
          end else begin
            pend_valid_nxt_s  = pend_valid_r;
          end
        end else if (redir_any_s) begin
          pend_valid_nxt_s = 1'b0;
          if (redir_bad_s) begin
            misaligned_nxt_s = 1'b1;
            pc_valid_nxt_s   = 1'b0;
          end else begin
            pc_nxt_s = redir_tgt_s;
          end
        end else begin
          // Call/ret only take effect when pc actually advances.
          ras_push_s = bus.call;
          ras_pop_s  = bus.ret && ras_nonempty_s;
          if (ras_pop_s) pc_nxt_s = ras_top_s;
          else           pc_nxt_s = seq_pc_s;
        end
      end
      HALT: begin
        if (bus.trap) begin
          pc_nxt_s         = TRAP_VECTOR;
          pc_valid_nxt_s   = 1'b1;
          pend_valid_nxt_s = 1'b0;
          ras_clr_s        = 1'b1;
        end else begin
          pc_valid_nxt_s   = 1'b0;
        end
      end
      default: begin
        pc_nxt_s       = RESET_VECTOR;
        pc_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_VECTOR;
      pc_valid_r    <= 1'b0;
      misaligned_r  <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
    end else begin
      pc_r          <= pc_nxt_s;
      pc_valid_r    <= pc_valid_nxt_s;
      misaligned_r  <= misaligned_nxt_s;
      pend_valid_r  <= pend_valid_nxt_s;
      pend_target_r <= pend_target_nxt_s;
    end
  end

  assign bus.pc         = pc_r;
  assign bus.pc_valid   = pc_valid_r;
  assign bus.misaligned = misaligned_r;

`ifdef PC_RAS_EN
  localparam int RAS_AW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0]   ras_mem_r [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_ptr_r, ras_ptr_nxt_s;
  logic [RAS_AW:0]   ras_cnt_r, ras_cnt_nxt_s;
  logic              ras_empty_r, ras_full_r;

  assign ras_top_s      = ras_mem_r[ras_ptr_r];
  assign ras_nonempty_s = (ras_cnt_r != '0);

  // Circular stack pointer/count; a push onto a full stack overwrites the oldest entry.
  always_comb begin
    ras_ptr_nxt_s = ras_ptr_r;
    ras_cnt_nxt_s = ras_cnt_r;
    if (ras_clr_s) begin
      ras_ptr_nxt_s = '0;
      ras_cnt_nxt_s = '0;
    end else if (ras_push_s && !ras_pop_s) begin
      ras_ptr_nxt_s = ras_ptr_r + RAS_AW'(1);
      if (ras_cnt_r != (RAS_AW+1)'(RAS_DEPTH)) ras_cnt_nxt_s = ras_cnt_r + (RAS_AW+1)'(1);
      else                                     ras_cnt_nxt_s = ras_cnt_r;
    end else if (ras_pop_s && !ras_push_s) begin
      ras_ptr_nxt_s = ras_ptr_r - RAS_AW'(1);
      ras_cnt_nxt_s = ras_cnt_r - (RAS_AW+1)'(1);
    end else begin
      ras_ptr_nxt_s = ras_ptr_r;
    end
  end

  // RAS pointer, count and registered status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_ptr_r   <= '0;
      ras_cnt_r   <= '0;
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      ras_ptr_r   <= ras_ptr_nxt_s;
      ras_cnt_r   <= ras_cnt_nxt_s;
      ras_empty_r <= (ras_cnt_nxt_s == '0);
      ras_full_r  <= (ras_cnt_nxt_s == (RAS_AW+1)'(RAS_DEPTH));
    end
  end

  // Push slot equals the next pointer for both plain push and pop-then-push.
  always_ff @(posedge clock) begin
    if (ras_push_s && !ras_clr_s) ras_mem_r[ras_ptr_nxt_s] <= seq_pc_s;
  end

  assign bus.ras_empty = ras_empty_r;
  assign bus.ras_full  = ras_full_r;
`else
  logic unused_s;

  assign ras_top_s      = seq_pc_s;
  assign ras_nonempty_s = 1'b0;
  assign unused_s       = ras_push_s ^ ras_pop_s ^ ras_clr_s ^ (RAS_DEPTH == 0);
  assign bus.ras_empty  = 1'b1;
  assign bus.ras_full   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS steps run only when PC_RAS_EN is defined.
module tb_pc_gen;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ret_pc_exp    [5] = '{32'h3C, 32'h38, 32'h34, 32'h30, 32'h34};
  logic        ret_empty_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] want_pc, input logic want_valid);
    chk({tag, ".pc"}, bus.pc, want_pc);
    chk({tag, ".valid"}, {31'd0, bus.pc_valid}, {31'd0, want_valid});
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] tgt, input logic tr);
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.trap            = tr;
  endtask

  initial begin
    reset    = 1'b1;
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk_pc("reset", 32'h0, 1'b0);
    chk("reset.mis", {31'd0, bus.misaligned}, 32'd0);
    chk("reset.empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("reset.full", {31'd0, bus.ras_full}, 32'd0);
    #11 reset = 1'b0;

    tick(); chk_pc("boot", 32'h0, 1'b1);
    tick(); chk_pc("run1", 32'h4, 1'b1);
    tick(); chk_pc("run2", 32'h8, 1'b1);
    tick(); chk_pc("run3", 32'hC, 1'b1);
    tick(); chk_pc("run4", 32'h10, 1'b1);

    // Stall with redirect in the first stall cycle.
    drive(1'b1, 1'b1, 32'h40, 1'b0); tick(); chk_pc("stall1", 32'h10, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);  tick(); chk_pc("stall2", 32'h10, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);  tick(); chk_pc("pend_apply", 32'h40, 1'b1);

    // Latest pending redirect wins.
    drive(1'b1, 1'b1, 32'h60, 1'b0); tick(); chk_pc("latest1", 32'h40, 1'b1);
    drive(1'b1, 1'b1, 32'h80, 1'b0); tick(); chk_pc("latest2", 32'h40, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);  tick(); chk_pc("latest_apply", 32'h80, 1'b1);
    tick(); chk_pc("after_pend", 32'h84, 1'b1);

    drive(1'b0, 1'b1, 32'h200, 1'b0); tick(); chk_pc("live_redir", 32'h200, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);   tick(); chk_pc("after_redir", 32'h204, 1'b1);

    // Misaligned target halts the fetch.
    drive(1'b0, 1'b1, 32'h42, 1'b0); tick();
    chk_pc("misal", 32'h204, 1'b0);
    chk("misal.pulse", {31'd0, bus.misaligned}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);  tick();
    chk_pc("halt", 32'h204, 1'b0);
    chk("misal.drop", {31'd0, bus.misaligned}, 32'd0);
    drive(1'b0, 1'b1, 32'h300, 1'b0); tick(); chk_pc("halt_redir", 32'h204, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);   tick(); chk_pc("halt_trap", 32'h100, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);   tick(); chk_pc("post_trap", 32'h104, 1'b1);

    // Trap beats stall, live redirect and an already pending redirect.
    drive(1'b1, 1'b1, 32'h500, 1'b0); tick(); chk_pc("pre_trap_pend", 32'h104, 1'b1);
    drive(1'b1, 1'b1, 32'h80, 1'b1);  tick(); chk_pc("trap_all", 32'h100, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);   tick(); chk_pc("trap_clr_pend", 32'h104, 1'b1);
    tick(); chk_pc("trap_clr_pend2", 32'h108, 1'b1);

    // Reset in the middle of a stall discards the pending redirect.
    drive(1'b1, 1'b1, 32'h600, 1'b0); tick(); chk_pc("pre_reset", 32'h108, 1'b1);
    reset = 1'b1; #1;
    chk_pc("mid_reset", 32'h0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick(); chk_pc("reboot", 32'h0, 1'b1);
    tick(); chk_pc("reboot_seq", 32'h4, 1'b1);

`ifdef PC_RAS_EN
    drive(1'b0, 1'b1, 32'h20, 1'b0); tick(); chk_pc("ras_go", 32'h20, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    bus.call = 1'b1; tick(); chk_pc("call1", 32'h24, 1'b1);
    bus.call = 1'b0;
    chk("call1.empty", {31'd0, bus.ras_empty}, 32'd0);
    tick(); tick(); tick(); chk_pc("to30", 32'h30, 1'b1);
    bus.call = 1'b1; tick(); chk_pc("call2", 32'h34, 1'b1);
    bus.call = 1'b0; bus.ret = 1'b1;
    tick(); chk_pc("ret1", 32'h34, 1'b1);
    tick(); chk_pc("ret2", 32'h24, 1'b1);
    chk("ret2.empty", {31'd0, bus.ras_empty}, 32'd1);
    tick(); chk_pc("ret_empty", 32'h28, 1'b1);
    bus.ret = 1'b0; bus.call = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_pc("call5", 32'h2C + 32'(4 * k), 1'b1);
      chk("call5.full", {31'd0, bus.ras_full}, (k >= 3) ? 32'd1 : 32'd0);
    end
    bus.call = 1'b0; bus.ret = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_pc("ret5", ret_pc_exp[k], 1'b1);
      chk("ret5.empty", {31'd0, bus.ras_empty}, {31'd0, ret_empty_exp[k]});
      chk("ret5.full", {31'd0, bus.ras_full}, 32'd0);
    end
    bus.ret = 1'b0;
`else
    bus.call = 1'b1; bus.ret = 1'b1;
    tick(); chk_pc("noras_ret", 32'h8, 1'b1);
    chk("noras.empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("noras.full", {31'd0, bus.ras_full}, 32'd0);
    bus.call = 1'b0; bus.ret = 1'b0;
`endif

    // Sequential wrap at the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0); tick(); chk_pc("top", 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);         tick(); chk_pc("wrap", 32'h0, 1'b1);
    chk("wrap.mis", {31'd0, bus.misaligned}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
